// File: rtl/frame_strobe_driver.sv
// frame_strobe_driver
//   Consumes a stream of config words (header, then data) and writes one
//   frame of a configuration column per accepted data word.
//   Header word: [31:24] sync (0xFA), [15:8] column, [4:0] frame index.
//   A good frame takes 4 cycles: header, data, strobe, gap.
//
// Ports
//   UserCLK      clock, rising edge
//   Reset        asynchronous, active-high
//   word_valid   upstream word valid
//   word_data    upstream word (header or data)
//   word_ready   word accepted this cycle when word_valid is also high
//   FrameData    registered frame payload to the column
//   FrameStrobe  one-hot frame write strobe, high for one cycle
//   busy         high whenever not IDLE
//   err_count    saturating count of bad-sync headers and out-of-range indices
module frame_strobe_driver #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int ColumnIndex     = 0
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic                       word_valid,
  input  logic [FrameBitsPerRow-1:0] word_data,
  output logic                       word_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic [7:0]                 err_count
);

  typedef enum logic [1:0] {IDLE, DATA, STROBE, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] col_q;
  logic [4:0] idx_q;
  logic       drop_q;

  logic [7:0] hdr_sync, hdr_col;
  logic [4:0] hdr_idx;
  logic       take, sync_ok, idx_bad, col_bad;

  assign hdr_sync = word_data[31:24];
  assign hdr_col  = word_data[15:8];
  assign hdr_idx  = word_data[4:0];

  assign sync_ok = (hdr_sync == 8'hFA);
  assign idx_bad = (int'(hdr_idx) >= MaxFramesPerCol);
  assign col_bad = (hdr_col != 8'(ColumnIndex));

  // Ready depends on state only, so no input-to-output combinational path.
  assign word_ready = (state == IDLE) || (state == DATA);
  assign busy       = (state != IDLE);
  assign take       = word_valid && word_ready;

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take && sync_ok) state_nxt = DATA;
      DATA:    if (take) state_nxt = drop_q ? IDLE : STROBE;
      STROBE:  state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      col_q     <= '0;
      idx_q     <= '0;
      drop_q    <= 1'b0;
      FrameData <= '0;
      err_count <= '0;
    end else begin
      if (state == IDLE && take) begin
        if (sync_ok) begin
          col_q  <= hdr_col;
          idx_q  <= hdr_idx;
          drop_q <= col_bad || idx_bad;
        end
        // A column mismatch is someone else's frame, not an error.
        if ((!sync_ok || idx_bad) && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
      // Dropped frames still consume their data word but leave FrameData alone.
      if (state == DATA && take && !drop_q)
        FrameData <= word_data;
    end
  end

  // Strobe decodes straight from registered state, so an async reset
  // kills it in the same cycle.
  always_comb begin
    FrameStrobe = '0;
    for (int i = 0; i < MaxFramesPerCol; i++)
      FrameStrobe[i] = (state == STROBE) && (int'(idx_q) == i);
  end

  // Latched column is kept for visibility of the frame in flight.
  logic col_seen;
  assign col_seen = ^col_q;
  logic unused_ok;
  assign unused_ok = col_seen | 1'b1;

endmodule
